// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter: FSM state encoding, index-width
// helper and default slot/tenure constants.
package bus_arb_pkg;

  // Fixed 2-bit state encoding.
  typedef enum logic [1:0] {
    StCpuOwn  = 2'b00,
    StArb     = 2'b01,
    StGrant   = 2'b10,
    StRelease = 2'b11
  } arb_state_e;

  localparam int unsigned DefCpuSlot = 1;
  localparam int unsigned DefMaxHold = 16;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: returns the first set request
// bit searching upward from rr_ptr_i+1, wrapping modulo NUM_REQ.
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  int unsigned cand;

  // Scan NUM_REQ positions starting just after the last winner.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(rr_ptr_i) + i) % NUM_REQ;
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shared memory bus arbiter between the CPU (default owner) and NUM_REQ DMA
// controllers using the BR/BG handshake, with round-robin grant order, one
// turnaround cycle and a minimum CPU slot between DMA tenures.
// Optional feature macro: BUS_TIMEOUT_EN enables the MAX_HOLD tenure limit
// and the revoke pulse when another DMAC is waiting.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned CPU_SLOT = DefCpuSlot,
  parameter int unsigned MAX_HOLD = DefMaxHold,
  localparam int unsigned IDX_W = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] br,
  input  logic               cpu_mem_busy,
  output logic [NUM_REQ-1:0] bg,
  output logic               cpu_hold,
  output logic               owner_valid,
  output logic [IDX_W-1:0]   owner_idx,
  output logic               revoke
);

  localparam int unsigned SlotW = idx_w(CPU_SLOT + 1);
  localparam logic [SlotW-1:0] SlotMax = SlotW'(CPU_SLOT);

  arb_state_e          state_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [SlotW-1:0]    slot_q;
  logic [NUM_REQ-1:0]  bg_q;
  logic                cpu_hold_q;
  logic                owner_valid_q;
  logic [IDX_W-1:0]    owner_idx_q;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TenW = idx_w(MAX_HOLD);
  localparam logic [TenW-1:0] TenMax = TenW'(MAX_HOLD - 1);

  logic [TenW-1:0]     tenure_q;
  logic                revoke_q;
  logic [NUM_REQ-1:0]  other_req;

  // Requests from everyone except the current owner.
  always_comb begin
    other_req = br & ~(NUM_REQ'(1) << owner_idx_q);
  end

  assign revoke = revoke_q;
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
  assign revoke = 1'b0;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .req_i    (br),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  // Arbitration FSM with counters and registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StCpuOwn;
      rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
      slot_q        <= SlotMax;
      bg_q          <= '0;
      cpu_hold_q    <= 1'b0;
      owner_valid_q <= 1'b0;
      owner_idx_q   <= '0;
`ifdef BUS_TIMEOUT_EN
      tenure_q      <= '0;
      revoke_q      <= 1'b0;
`endif
    end else begin
`ifdef BUS_TIMEOUT_EN
      revoke_q <= 1'b0;
`endif
      unique case (state_q)
        StCpuOwn: begin
          if (slot_q < SlotMax) slot_q <= slot_q + SlotW'(1);
          // pick_valid mirrors |br; both are kept for readability.
          if (pick_valid && !cpu_mem_busy && (slot_q >= SlotMax)) begin
            cpu_hold_q  <= 1'b1;
            owner_idx_q <= pick_idx;
            state_q     <= StArb;
          end
        end
        StArb: begin
          if (br[owner_idx_q]) begin
            bg_q          <= NUM_REQ'(1) << owner_idx_q;
            owner_valid_q <= 1'b1;
            rr_ptr_q      <= owner_idx_q;
`ifdef BUS_TIMEOUT_EN
            tenure_q      <= '0;
`endif
            state_q       <= StGrant;
          end else begin
            // Request withdrawn before the grant: give the bus straight back.
            state_q <= StRelease;
          end
        end
        StGrant: begin
          if (!br[owner_idx_q]) begin
            bg_q          <= '0;
            owner_valid_q <= 1'b0;
            state_q       <= StRelease;
          end
`ifdef BUS_TIMEOUT_EN
          else if ((tenure_q == TenMax) && (|other_req)) begin
            bg_q          <= '0;
            owner_valid_q <= 1'b0;
            revoke_q      <= 1'b1;
            state_q       <= StRelease;
          end else if (tenure_q != TenMax) begin
            tenure_q <= tenure_q + TenW'(1);
          end
`endif
        end
        StRelease: begin
          cpu_hold_q <= 1'b0;
          slot_q     <= '0;
          state_q    <= StCpuOwn;
        end
        default: state_q <= StCpuOwn;
      endcase
    end
  end

  assign bg          = bg_q;
  assign cpu_hold    = cpu_hold_q;
  assign owner_valid = owner_valid_q;
  assign owner_idx   = owner_idx_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (NUM_REQ=2, CPU_SLOT=1,
// MAX_HOLD=16). The tenure-limit section follows BUS_TIMEOUT_EN.
module tb_bus_arbiter;

  logic       clk;
  logic       reset_n;
  logic [1:0] br;
  logic       cpu_mem_busy;
  logic [1:0] bg;
  logic       cpu_hold;
  logic       owner_valid;
  logic [0:0] owner_idx;
  logic       revoke;

  int n_cmp;
  int n_err;

  bus_arbiter #(
    .NUM_REQ  (2),
    .CPU_SLOT (1),
    .MAX_HOLD (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .br           (br),
    .cpu_mem_busy (cpu_mem_busy),
    .bg           (bg),
    .cpu_hold     (cpu_hold),
    .owner_valid  (owner_valid),
    .owner_idx    (owner_idx),
    .revoke       (revoke)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset_n      = 1'b0;
    br           = 2'b00;
    cpu_mem_busy = 1'b0;

    // Reset state
    #3;
    chk("rst_bg", 32'(bg), 32'h0);
    chk("rst_hold", 32'(cpu_hold), 32'h0);
    chk("rst_ov", 32'(owner_valid), 32'h0);
    chk("rst_idx", 32'(owner_idx), 32'h0);
    chk("rst_revoke", 32'(revoke), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Single request: hold after one edge, grant after two
    br = 2'b01;
    tick();
    chk("single_hold", 32'(cpu_hold), 32'h1);
    chk("single_bg_early", 32'(bg), 32'h0);
    tick();
    chk("single_bg", 32'(bg), 32'h1);
    chk("single_ov", 32'(owner_valid), 32'h1);
    chk("single_idx", 32'(owner_idx), 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("single_bg_held", 32'(bg), 32'h1);
    br = 2'b00;
    tick();
    chk("single_drop_bg", 32'(bg), 32'h0);
    chk("single_drop_ov", 32'(owner_valid), 32'h0);
    chk("single_release_hold", 32'(cpu_hold), 32'h1);
    tick();
    chk("single_cpu_back", 32'(cpu_hold), 32'h0);

    // CPU busy blocks the takeover
    br           = 2'b10;
    cpu_mem_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("busy_hold_low", 32'(cpu_hold), 32'h0);
    end
    cpu_mem_busy = 1'b0;
    tick();
    chk("busy_hold_rise", 32'(cpu_hold), 32'h1);
    tick();
    chk("busy_bg", 32'(bg), 32'h2);
    chk("busy_idx", 32'(owner_idx), 32'h1);
    br = 2'b00;
    tick();
    chk("busy_drop_bg", 32'(bg), 32'h0);
    tick();
    chk("busy_cpu_back", 32'(cpu_hold), 32'h0);

    // Round robin with both requesting; one-cycle drop ends each tenure
    br = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_bg;
      exp_bg = (k % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      chk("rr_slot_hold", 32'(cpu_hold), 32'h0);
      tick();
      chk("rr_arb_hold", 32'(cpu_hold), 32'h1);
      chk("rr_arb_bg", 32'(bg), 32'h0);
      tick();
      chk("rr_grant", 32'(bg), 32'(exp_bg));
      for (int i = 0; i < 10; i++) begin
        tick();
        chk("rr_grant_stable", 32'(bg), 32'(exp_bg));
      end
      br = 2'b11 & ~exp_bg;
      tick();
      chk("rr_release_bg", 32'(bg), 32'h0);
      chk("rr_release_hold", 32'(cpu_hold), 32'h1);
      br = 2'b11;
      tick();
      chk("rr_cpu_back", 32'(cpu_hold), 32'h0);
    end
    br = 2'b00;
    tick();
    tick();

    // Request withdrawn during ARB
    br = 2'b01;
    tick();
    chk("wd_hold1", 32'(cpu_hold), 32'h1);
    br = 2'b00;
    tick();
    chk("wd_hold2", 32'(cpu_hold), 32'h1);
    chk("wd_bg", 32'(bg), 32'h0);
    chk("wd_ov", 32'(owner_valid), 32'h0);
    tick();
    chk("wd_cpu_back", 32'(cpu_hold), 32'h0);
    chk("wd_bg_after", 32'(bg), 32'h0);
    tick();
    tick();

    // Async reset mid-GRANT; DMAC0 owns the bus so rr_ptr is 0 beforehand
    br = 2'b01;
    tick();
    tick();
    chk("ar_pre_bg", 32'(bg), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_bg", 32'(bg), 32'h0);
    chk("ar_hold", 32'(cpu_hold), 32'h0);
    chk("ar_ov", 32'(owner_valid), 32'h0);
    br = 2'b11;
    tick();
    reset_n = 1'b1;
    tick();
    chk("ar_post_hold", 32'(cpu_hold), 32'h1);
    tick();
    chk("ar_post_bg", 32'(bg), 32'h1);
    chk("ar_post_idx", 32'(owner_idx), 32'h0);

`ifdef BUS_TIMEOUT_EN
    // DMAC1 waiting: DMAC0 is revoked after 16 grant cycles
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_bg_held", 32'(bg), 32'h1);
      chk("to_no_revoke", 32'(revoke), 32'h0);
    end
    tick();
    chk("to_revoke", 32'(revoke), 32'h1);
    chk("to_bg_off", 32'(bg), 32'h0);
    chk("to_ov_off", 32'(owner_valid), 32'h0);
    tick();
    chk("to_revoke_pulse", 32'(revoke), 32'h0);
    chk("to_cpu_back", 32'(cpu_hold), 32'h0);
    tick();
    tick();
    chk("to_hold_next", 32'(cpu_hold), 32'h1);
    tick();
    chk("to_next_bg", 32'(bg), 32'h2);
    br = 2'b01;
    tick();
    chk("to_next_drop", 32'(bg), 32'h0);
    tick();
    tick();
    tick();
    tick();
    chk("to_regrant", 32'(bg), 32'h1);
    // Alone on the bus: no limit
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("alone_bg", 32'(bg), 32'h1);
      chk("alone_no_revoke", 32'(revoke), 32'h0);
    end
`else
    // No tenure limit even with DMAC1 waiting
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("nolimit_bg", 32'(bg), 32'h1);
      chk("nolimit_revoke", 32'(revoke), 32'h0);
    end
`endif
    br = 2'b00;
    tick();
    chk("end_bg", 32'(bg), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
